// File: rtl/siso_rsc_encoder_pkg.sv
// Shared constants and trellis helpers for the LTE constituent RSC encoder.
// rsc_step is the single source of the g0=13/g1=15 recursion.
package siso_rsc_encoder_pkg;

    localparam int DW    = 16;
    localparam int AMP   = 1024;
    localparam int K_MIN = 40;
    localparam int K_MAX = 6144;
    localparam int CW    = 13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ENC  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    // s = {s1,s2,s3}; returns {s', z}
    function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic x);
        logic a;
        a = x ^ s[1] ^ s[0];
        return {a, s[2], s[1], a ^ s[2] ^ s[0]};
    endfunction

    function automatic logic signed [DW-1:0] bpsk(input logic b);
        return b ? -DW'(AMP) : DW'(AMP);
    endfunction

endpackage

// File: rtl/siso_rsc_encoder_if.sv
// Block-start, bit-input and symbol-output signals of the RSC encoder.
interface siso_rsc_encoder_if;
    import siso_rsc_encoder_pkg::*;

    logic [15:0]          blklen;
    logic                 valid_blklen;
    logic                 bit_in;
    logic                 valid_bit;
    logic                 ready_bit;
    logic signed [DW-1:0] out;
    logic                 valid_out;
    logic                 last_out;
    logic                 busy;
    logic                 blklen_err;

    modport master (
        output blklen, valid_blklen, bit_in, valid_bit,
        input  ready_bit, out, valid_out, last_out, busy, blklen_err
    );

    modport slave (
        input  blklen, valid_blklen, bit_in, valid_bit,
        output ready_bit, out, valid_out, last_out, busy, blklen_err
    );

endinterface

// File: rtl/siso_rsc_encoder_trellis.sv
// 8-state RSC trellis register with feedback/parity and termination input mux.
module siso_rsc_encoder_trellis
    import siso_rsc_encoder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic step_i,
    input  logic term_i,
    input  logic bit_i,
    output logic sys_o,
    output logic par_o
);

    logic [2:0] s_q, s_d;
    logic       x;
    logic [3:0] nxt;

    // Termination feeds back s2^s3 so the register input becomes 0
    always_comb begin
        x   = term_i ? (s_q[1] ^ s_q[0]) : bit_i;
        nxt = rsc_step(s_q, x);
        s_d = s_q;
        if (clr_i)
            s_d = '0;
        else if (step_i)
            s_d = nxt[3:1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s_q <= '0;
        else
            s_q <= s_d;
    end

    assign sys_o = x;
    assign par_o = nxt[0];

endmodule

// File: rtl/siso_rsc_encoder.sv
// RSC encoder top: block FSM, bit/tail counters and registered BPSK symbol output.
module siso_rsc_encoder
    import siso_rsc_encoder_pkg::*;
(
    input logic               clk,
    input logic               rst,
    siso_rsc_encoder_if.slave enc
);

    logic [1:0]           st_q, st_d;
    logic                 ph_q, ph_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        k_q, k_d;
    logic [1:0]           tc_q, tc_d;
    logic                 z_q, z_d;
    logic signed [DW-1:0] out_q, out_d;
    logic                 vo_q, vo_d;
    logic                 lo_q, lo_d;
    logic                 err_q, err_d;
    logic                 blk_ok, clr, step, term, sys, par;

    assign blk_ok = (enc.blklen >= 16'(K_MIN)) && (enc.blklen <= 16'(K_MAX));
    assign clr    = (st_q == ST_IDLE) && enc.valid_blklen && blk_ok;
    assign step   = ((st_q == ST_ENC) && !ph_q && enc.valid_bit)
                  || ((st_q == ST_TAIL) && !ph_q);
    assign term   = (st_q == ST_TAIL);

    siso_rsc_encoder_trellis u_trl (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .step_i(step),
        .term_i(term),
        .bit_i (enc.bit_in),
        .sys_o (sys),
        .par_o (par)
    );

    always_comb begin
        st_d  = st_q;
        ph_d  = ph_q;
        cnt_d = cnt_q;
        k_d   = k_q;
        tc_d  = tc_q;
        z_d   = z_q;
        out_d = out_q;
        vo_d  = 1'b0;
        lo_d  = 1'b0;
        err_d = 1'b0;
        unique case (1'b1)
            st_q == ST_IDLE: begin
                if (enc.valid_blklen) begin
                    if (blk_ok) begin
                        st_d  = ST_ENC;
                        k_d   = enc.blklen[CW-1:0];
                        cnt_d = '0;
                        ph_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            (st_q == ST_ENC) && !ph_q: begin
                if (enc.valid_bit) begin
                    out_d = bpsk(enc.bit_in);
                    vo_d  = 1'b1;
                    z_d   = par;
                    ph_d  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            (st_q == ST_ENC) && ph_q: begin
                out_d = bpsk(z_q);
                vo_d  = 1'b1;
                ph_d  = 1'b0;
                if (cnt_q == k_q) begin
                    st_d = ST_TAIL;
                    tc_d = '0;
                end
            end
            (st_q == ST_TAIL) && !ph_q: begin
                out_d = bpsk(sys);
                vo_d  = 1'b1;
                z_d   = par;
                ph_d  = 1'b1;
            end
            (st_q == ST_TAIL) && ph_q: begin
                out_d = bpsk(z_q);
                vo_d  = 1'b1;
                ph_d  = 1'b0;
                tc_d  = tc_q + 1'b1;
                if (tc_q == 2'd2) begin
                    lo_d = 1'b1;
                    st_d = ST_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            ph_q  <= 1'b0;
            cnt_q <= '0;
            k_q   <= '0;
            tc_q  <= '0;
            z_q   <= 1'b0;
            out_q <= '0;
            vo_q  <= 1'b0;
            lo_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            ph_q  <= ph_d;
            cnt_q <= cnt_d;
            k_q   <= k_d;
            tc_q  <= tc_d;
            z_q   <= z_d;
            out_q <= out_d;
            vo_q  <= vo_d;
            lo_q  <= lo_d;
            err_q <= err_d;
        end
    end

    assign enc.ready_bit  = (st_q == ST_ENC) && !ph_q;
    assign enc.busy       = (st_q != ST_IDLE) || lo_q;
    assign enc.out        = out_q;
    assign enc.valid_out  = vo_q;
    assign enc.last_out   = lo_q;
    assign enc.blklen_err = err_q;

endmodule

// File: tb/tb_siso_rsc_encoder.sv
// Directed bench for siso_rsc_encoder against an independent bit-level RSC model.
module tb_siso_rsc_encoder;

    localparam logic signed [15:0] PA = 16'sd1024;
    localparam logic signed [15:0] NA = -16'sd1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    siso_rsc_encoder_if ifc ();

    siso_rsc_encoder dut (
        .clk(clk),
        .rst(rst),
        .enc(ifc)
    );

    logic               bits_a[6144];
    logic signed [15:0] got_w[$];
    logic signed [15:0] exp_w[$];
    bit                 got_l[$];
    int ncmp = 0;
    int nerr = 0;
    int gaps_in;
    int bad_gaps;
    bit timed_out;

    function automatic logic signed [15:0] mapb(input logic b);
        return b ? NA : PA;
    endfunction

    // g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3 feedforward; r1..r3 = delay taps
    task automatic build_exp(input int k);
        logic r1, r2, r3, fb, p;
        r1 = 0; r2 = 0; r3 = 0;
        exp_w.delete();
        for (int i = 0; i < k; i++) begin
            fb = bits_a[i] ^ r2 ^ r3;
            p  = fb ^ r1 ^ r3;
            exp_w.push_back(mapb(bits_a[i]));
            exp_w.push_back(mapb(p));
            r3 = r2; r2 = r1; r1 = fb;
        end
        for (int t = 0; t < 3; t++) begin
            exp_w.push_back(mapb(r2 ^ r3));
            exp_w.push_back(mapb(r1 ^ r3));
            r3 = r2; r2 = r1; r1 = 0;
        end
    endtask

    task automatic fill_bits(input int k, input int mode);
        for (int i = 0; i < k; i++)
            bits_a[i] = (mode == 0) ? 1'b0 :
                        (mode == 1) ? (i == 0) : 1'($urandom_range(0, 1));
    endtask

    task automatic run_block(input int k, input bit toggle, input int inject);
        int idx;
        int cyc;
        bit done;
        bit started;
        bit prev_noacc;
        idx = 0; cyc = 0; done = 0; started = 0; prev_noacc = 1;
        gaps_in = 0; bad_gaps = 0; timed_out = 0;
        got_w.delete(); got_l.delete();
        @(negedge clk);
        ifc.blklen = 16'(k);
        ifc.valid_blklen = 1'b1;
        @(negedge clk);
        ifc.valid_blklen = 1'b0;
        while (!done && cyc < 40000) begin
            if (ifc.valid_out) begin
                got_w.push_back(ifc.out);
                got_l.push_back(ifc.last_out);
                started = 1;
                if (ifc.last_out) done = 1;
            end else if (started) begin
                gaps_in++;
                if (!prev_noacc) bad_gaps++;
            end
            ifc.valid_blklen = (cyc == inject);
            ifc.blklen = 16'd512;
            if (idx < k) begin
                ifc.bit_in = bits_a[idx];
                ifc.valid_bit = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                ifc.valid_bit = 1'b0;
            end
            prev_noacc = ifc.ready_bit && !ifc.valid_bit;
            if (ifc.valid_bit && ifc.ready_bit) idx++;
            if (!done) @(negedge clk);
            cyc++;
        end
        ifc.valid_bit = 1'b0;
        ifc.valid_blklen = 1'b0;
        if (!done) timed_out = 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ncmp++;
        if ({ifc.out, ifc.valid_out, ifc.ready_bit, ifc.busy, ifc.last_out, ifc.blklen_err} !== 21'd0) begin
            nerr++;
            $display("FAIL reset_idle: out=%0d vo=%b rdy=%b busy=%b got nonzero, need all 0",
                     ifc.out, ifc.valid_out, ifc.ready_bit, ifc.busy);
        end
        ifc.blklen = 16'd40;
        ifc.valid_blklen = 1'b1;
        @(negedge clk);
        ifc.valid_blklen = 1'b0;
        ifc.valid_bit = 1'b1;
        ifc.bit_in = 1'b1;
        repeat (9) @(negedge clk);
        ncmp++;
        if (ifc.busy !== 1'b1) begin
            nerr++;
            $display("FAIL busy_midblock: got %b need 1", ifc.busy);
        end
        #1 rst = 1'b1;
        #1;
        ncmp++;
        if ({ifc.out, ifc.valid_out, ifc.ready_bit, ifc.busy, ifc.last_out} !== 20'd0) begin
            nerr++;
            $display("FAIL reset_mid: out=%0d vo=%b rdy=%b busy=%b lo=%b need all 0",
                     ifc.out, ifc.valid_out, ifc.ready_bit, ifc.busy, ifc.last_out);
        end
        ncmp++;
        if (dut.u_trl.s_q !== 3'b000) begin
            nerr++;
            $display("FAIL reset_trellis: got %b need 000", dut.u_trl.s_q);
        end
        ifc.valid_bit = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        ncmp++;
        if (ifc.valid_out !== 1'b0 || ifc.busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_no_tail: vo=%b busy=%b need 0 0", ifc.valid_out, ifc.busy);
        end
    endtask

    task automatic test_all_zero;
        int sh;
        fill_bits(40, 0);
        run_block(40, 0, -1);
        sh = 0;
        ncmp++;
        if (timed_out || got_w.size() != 86) begin
            nerr++;
            $display("FAIL zero_count: got %0d words need 86", got_w.size());
        end
        for (int i = 0; i < got_w.size(); i++) begin
            ncmp++;
            if (got_w[i] !== PA || got_l[i] !== (i == 85)) begin
                nerr++;
                if (sh++ < 4)
                    $display("FAIL zero_word[%0d]: got %0d last=%b need %0d last=%b",
                             i, got_w[i], got_l[i], PA, i == 85);
            end
        end
        ncmp++;
        if (gaps_in != 0) begin
            nerr++;
            $display("FAIL zero_gaps: got %0d gaps need 0", gaps_in);
        end
    endtask

    task automatic test_impulse;
        logic signed [15:0] hand[4];
        int sh;
        hand[0] = NA; hand[1] = NA; hand[2] = PA; hand[3] = NA;
        fill_bits(40, 1);
        build_exp(40);
        run_block(40, 0, -1);
        sh = 0;
        ncmp++;
        if (timed_out || got_w.size() != 86) begin
            nerr++;
            $display("FAIL imp_count: got %0d words need 86", got_w.size());
        end
        for (int i = 0; i < 4 && i < got_w.size(); i++) begin
            ncmp++;
            if (got_w[i] !== hand[i]) begin
                nerr++;
                $display("FAIL imp_hand[%0d]: got %0d need %0d", i, got_w[i], hand[i]);
            end
        end
        for (int i = 0; i < got_w.size() && i < 86; i++) begin
            ncmp++;
            if (got_w[i] !== exp_w[i]) begin
                nerr++;
                if (sh++ < 4)
                    $display("FAIL imp_word[%0d]: got %0d need %0d", i, got_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_gapped;
        int sh;
        fill_bits(512, 2);
        build_exp(512);
        for (int pass = 0; pass < 2; pass++) begin
            run_block(512, pass == 1, -1);
            sh = 0;
            ncmp++;
            if (timed_out || got_w.size() != 1030) begin
                nerr++;
                $display("FAIL gap_count[%0d]: got %0d words need 1030", pass, got_w.size());
            end
            for (int i = 0; i < got_w.size() && i < 1030; i++) begin
                ncmp++;
                if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 1029)) begin
                    nerr++;
                    if (sh++ < 4)
                        $display("FAIL gap_word[%0d][%0d]: got %0d last=%b need %0d",
                                 pass, i, got_w[i], got_l[i], exp_w[i]);
                end
            end
            ncmp++;
            if (bad_gaps != 0 || (pass == 0 && gaps_in != 0)) begin
                nerr++;
                $display("FAIL gap_where[%0d]: got %0d unexplained of %0d gaps need 0",
                         pass, bad_gaps, gaps_in);
            end
        end
    endtask

    task automatic test_blklen_err;
        int bad[2];
        int sh;
        bad[0] = 39; bad[1] = 6145;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            ifc.blklen = 16'(bad[j]);
            ifc.valid_blklen = 1'b1;
            @(negedge clk);
            ifc.valid_blklen = 1'b0;
            ncmp++;
            if (ifc.blklen_err !== 1'b1 || ifc.busy !== 1'b0) begin
                nerr++;
                $display("FAIL err_pulse[%0d]: err=%b busy=%b need 1 0",
                         bad[j], ifc.blklen_err, ifc.busy);
            end
            @(negedge clk);
            ncmp++;
            if (ifc.blklen_err !== 1'b0 || ifc.busy !== 1'b0) begin
                nerr++;
                $display("FAIL err_clear[%0d]: err=%b busy=%b need 0 0",
                         bad[j], ifc.blklen_err, ifc.busy);
            end
        end
        fill_bits(40, 2);
        build_exp(40);
        run_block(40, 0, 10);
        sh = 0;
        ncmp++;
        if (timed_out || got_w.size() != 86) begin
            nerr++;
            $display("FAIL busy_ignore_count: got %0d words need 86", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < 86; i++) begin
            ncmp++;
            if (got_w[i] !== exp_w[i]) begin
                nerr++;
                if (sh++ < 4)
                    $display("FAIL busy_ignore_word[%0d]: got %0d need %0d", i, got_w[i], exp_w[i]);
            end
        end
        @(negedge clk);
        ncmp++;
        if (ifc.busy !== 1'b0) begin
            nerr++;
            $display("FAIL busy_ignore_idle: busy=%b need 0", ifc.busy);
        end
    endtask

    task automatic test_kmax;
        int sh;
        fill_bits(6144, 2);
        build_exp(6144);
        run_block(6144, 0, -1);
        sh = 0;
        ncmp++;
        if (timed_out || got_w.size() != 12294) begin
            nerr++;
            $display("FAIL kmax_count: got %0d words need 12294", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < 12294; i++) begin
            ncmp++;
            if (got_w[i] !== exp_w[i] || got_l[i] !== (i == 12293)) begin
                nerr++;
                if (sh++ < 4)
                    $display("FAIL kmax_word[%0d]: got %0d last=%b need %0d",
                             i, got_w[i], got_l[i], exp_w[i]);
            end
        end
        ncmp++;
        if (dut.u_trl.s_q !== 3'b000) begin
            nerr++;
            $display("FAIL kmax_final_state: got %b need 000", dut.u_trl.s_q);
        end
    endtask

    initial begin
        ifc.blklen = '0;
        ifc.valid_blklen = 1'b0;
        ifc.bit_in = 1'b0;
        ifc.valid_bit = 1'b0;
        test_reset();
        test_impulse();
        test_all_zero();
        test_gapped();
        test_blklen_err();
        test_kmax();
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
